// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data RAM arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_HOST
  } owner_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  localparam int STAT_W   = 16;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/dmem_arb_stats.sv
// rtl/dmem_arb_stats.sv - saturating core-stall and host-grant counters
// Instantiated by dmem_arbiter only when DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_stall,
  input  logic              host_gnt,
  output logic [STAT_W-1:0] stat_core_stalls,
  output logic [STAT_W-1:0] stat_host_grants
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_core_stalls <= '0;
      stat_host_grants <= '0;
    end else begin
      if (core_stall && (stat_core_stalls != {STAT_W{1'b1}}))
        stat_core_stalls <= stat_core_stalls + 1'b1;
      if (host_gnt && (stat_host_grants != {STAT_W{1'b1}}))
        stat_host_grants <= stat_host_grants + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data RAM arbiter between core load/store and host port
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_core_stalls,
  output logic [STAT_W-1:0] stat_host_grants
`endif
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state, state_nxt;
  logic [STARVE_W-1:0] starve_cnt;
  owner_e              owner;
  logic                core_gnt;
  logic [DATA_W-1:0]   core_rdata_q, host_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // A locked host keeps the port; once lock is seen low the cycle arbitrates as IDLE.
  always_comb begin
    core_gnt  = 1'b0;
    host_gnt  = 1'b0;
    state_nxt = state;
    if (state == ARB_LOCKED && host_lock) begin
      host_gnt = host_req;
    end else begin
      if (core_req && host_req) begin
        if (starve_cnt == LIMIT) host_gnt = 1'b1;
        else                     core_gnt = 1'b1;
      end else begin
        core_gnt = core_req;
        host_gnt = host_req;
      end
      state_nxt = (host_gnt && host_lock) ? ARB_LOCKED : ARB_IDLE;
    end
  end

  assign core_stall = core_req & ~core_gnt;

  always_comb begin
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    if (core_gnt) begin
      ram_read  = ~core_we;
      ram_write = core_we;
      ram_addr  = core_addr;
      ram_din   = core_wdata;
    end else if (host_gnt) begin
      ram_read  = ~host_we;
      ram_write = host_we;
      ram_addr  = host_addr;
      ram_din   = host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (host_gnt || !host_req)
      starve_cnt <= '0;
    else if (core_gnt && (starve_cnt != LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    owner <= OWN_NONE;
    else if (core_gnt && !core_we) owner <= OWN_CORE;
    else if (host_gnt && !host_we) owner <= OWN_HOST;
    else                           owner <= OWN_NONE;
  end

  // The non-owning requester keeps showing its last returned word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      if (owner == OWN_CORE) core_rdata_q <= ram_dout;
      if (owner == OWN_HOST) host_rdata_q <= ram_dout;
    end
  end

  assign core_rvalid = (owner == OWN_CORE);
  assign host_rvalid = (owner == OWN_HOST);
  assign core_rdata  = core_rvalid ? ram_dout : core_rdata_q;
  assign host_rdata  = host_rvalid ? ram_dout : host_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk              (clk),
    .rst_n            (rst_n),
    .core_stall       (core_stall),
    .host_gnt         (host_gnt),
    .stat_core_stalls (stat_core_stalls),
    .stat_host_grants (stat_host_grants)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
// Stats checks are compiled in when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       core_req, core_we, core_stall, core_rvalid;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       ram_read, ram_write;
  logic [7:0] ram_addr, ram_din;
  logic [7:0] ram_dout = 8'h00;
`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_core_stalls, stat_host_grants;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256] = '{8'h01: 8'h11, 8'h02: 8'h22, 8'h10: 8'hA5, default: 8'h00};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    if (ram_read)  ram_dout      <= mem[ram_addr];
  end

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_stall  (core_stall),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_lock   (host_lock),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_core_stalls (stat_core_stalls),
    .stat_host_grants (stat_host_grants)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic hr, input logic hw, input logic hl,
                       input logic [7:0] ha, input logic [7:0] hd);
    @(negedge clk);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
    #1;
  endtask

  // Host must keep its request up until it has been granted.
  logic host_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_pend <= 1'b0;
    end else begin
      if (host_pend) begin
        checks++;
        assert (host_req === 1'b1) else begin
          errors++;
          $error("FAIL host_hold: observed host_req %0b expected 1", host_req);
        end
      end
      host_pend <= host_req & ~host_gnt;
    end
  end

  initial begin
    rst_n = 1'b0;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    host_req = 0; host_we = 0; host_lock = 0; host_addr = 0; host_wdata = 0;
    @(posedge clk); #1;
    chk("rst_core_rvalid", core_rvalid, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_state", 32'(dut.state), 32'(ARB_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Core load from 0x10
    drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("ld_stall", core_stall, 0);
    chk("ld_ram_read", ram_read, 1);
    chk("ld_ram_addr", ram_addr, 8'h10);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("ld_ram_read_off", ram_read, 0);
    chk("ld_rvalid", core_rvalid, 1);
    chk("ld_rdata", core_rdata, 8'hA5);
    chk("ld_host_rvalid", host_rvalid, 0);

    // Starvation: C,C,C,C,H,C,C,C,C,H
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'h02, 8'h00, 1, 0, 0, 8'h01, 8'h00);
      chk($sformatf("starve_hgnt_%0d", i), host_gnt, (i == 4 || i == 9) ? 1 : 0);
      chk($sformatf("starve_stall_%0d", i), core_stall, (i == 4 || i == 9) ? 1 : 0);
    end
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_host_grants", stat_host_grants, 2);
    chk("stat_core_stalls", stat_core_stalls, 2);
`endif

    // Locked host write of 0x3C to 0x20
    drive(0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h20, 8'h3C);
    chk("lk_hgnt", host_gnt, 1);
    chk("lk_ram_write", ram_write, 1);
    chk("lk_ram_addr", ram_addr, 8'h20);
    chk("lk_ram_din", ram_din, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'h20, 8'h00, 0, 0, 1, 8'h00, 8'h00);
      chk($sformatf("lk_stall_%0d", i), core_stall, 1);
      chk($sformatf("lk_noread_%0d", i), ram_read, 0);
    end
    drive(1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("unlk_stall", core_stall, 0);
    chk("unlk_ram_read", ram_read, 1);
    chk("unlk_ram_addr", ram_addr, 8'h20);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("unlk_rvalid", core_rvalid, 1);
    chk("unlk_rdata", core_rdata, 8'h3C);
    chk("unlk_state", 32'(dut.state), 32'(ARB_IDLE));

    // Alternating host then core reads
    drive(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 8'h00);
    chk("alt_hgnt", host_gnt, 1);
    drive(1, 0, 8'h02, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("alt_core_gnt", core_stall, 0);
    chk("alt_host_rvalid", host_rvalid, 1);
    chk("alt_host_rdata", host_rdata, 8'h11);
    chk("alt_core_rvalid0", core_rvalid, 0);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("alt_core_rvalid", core_rvalid, 1);
    chk("alt_core_rdata", core_rdata, 8'h22);
    chk("alt_host_rvalid0", host_rvalid, 0);
    chk("alt_host_hold", host_rdata, 8'h11);

    // Reset pulse right after a core read acceptance
    drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("rp_ram_read", ram_read, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    core_req = 1'b0;
    #1;
    chk("rp_rvalid", core_rvalid, 0);
    chk("rp_rdata", core_rdata, 0);
    chk("rp_state", 32'(dut.state), 32'(ARB_IDLE));
    chk("rp_starve", 32'(dut.starve_cnt), 0);
`ifdef DMEM_ARB_STATS_EN
    chk("rp_stat_host", stat_host_grants, 0);
    chk("rp_stat_core", stat_core_stalls, 0);
`endif
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("rp_rvalid_late", core_rvalid, 0);
    chk("rp_host_rvalid_late", host_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
